// File: rtl/char_min_select.sv
// Per-position minimum-difference template tracker for one plate frame.
// Emits the packed best index/diff vectors with a one-cycle valid pulse.
module char_min_select #(
  parameter int              CHAR_NUM     = 7,
  parameter int              IDX_W        = 4,
  parameter int              DIFF_W       = 16,
  parameter logic [IDX_W-1:0] NO_MATCH_IDX = 4'hA
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       frame_start,
  input  logic                       frame_end,
  input  logic                       cmp_valid,
  input  logic [2:0]                 cmp_pos,
  input  logic [IDX_W-1:0]           cmp_idx,
  input  logic [DIFF_W-1:0]          cmp_diff,
  output logic [CHAR_NUM*IDX_W-1:0]  char_index_c,
  output logic [CHAR_NUM*DIFF_W-1:0] char_diff_c,
  output logic                       char_valid_c,
  output logic                       busy,
  output logic                       pos_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CHAR_NUM-1:0][IDX_W-1:0]  r_min_idx;
  logic [CHAR_NUM-1:0][DIFF_W-1:0] r_min_diff;
  logic [CHAR_NUM-1:0][IDX_W-1:0]  w_idx_upd;
  logic [CHAR_NUM-1:0][DIFF_W-1:0] w_diff_upd;
  logic [CHAR_NUM-1:0][IDX_W-1:0]  r_out_idx;
  logic [CHAR_NUM-1:0][DIFF_W-1:0] r_out_diff;
  logic                            r_pos_err;
  logic                            w_pos_ok;

  assign w_pos_ok = ({29'd0, cmp_pos} < 32'(CHAR_NUM));

  // Candidate min set including this cycle's sample; ties keep the older entry.
  always_comb begin
    w_idx_upd  = r_min_idx;
    w_diff_upd = r_min_diff;
    for (int i = 0; i < CHAR_NUM; i++) begin
      if (cmp_valid && ({29'd0, cmp_pos} == 32'(i)) &&
          (cmp_diff < r_min_diff[i])) begin
        w_idx_upd[i]  = cmp_idx;
        w_diff_upd[i] = cmp_diff;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (frame_start) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        if (frame_start)    w_state_nxt = COLLECT;
        else if (frame_end) w_state_nxt = OUTPUT;
      end
      OUTPUT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= IDLE;
      r_min_idx  <= {CHAR_NUM{NO_MATCH_IDX}};
      r_min_diff <= '1;
      r_out_idx  <= {CHAR_NUM{NO_MATCH_IDX}};
      r_out_diff <= '1;
      r_pos_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_min_idx  <= {CHAR_NUM{NO_MATCH_IDX}};
            r_min_diff <= '1;
            r_pos_err  <= 1'b0;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            r_min_idx  <= {CHAR_NUM{NO_MATCH_IDX}};
            r_min_diff <= '1;
            r_pos_err  <= 1'b0;
          end else begin
            r_min_idx  <= w_idx_upd;
            r_min_diff <= w_diff_upd;
            if (cmp_valid && !w_pos_ok) r_pos_err <= 1'b1;
            if (frame_end) begin
              r_out_idx  <= w_idx_upd;
              r_out_diff <= w_diff_upd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign char_index_c = r_out_idx;
  assign char_diff_c  = r_out_diff;
  assign char_valid_c = (r_state == OUTPUT);
  assign busy         = (r_state == COLLECT);
  assign pos_err      = r_pos_err;

endmodule

// File: tb/tb_char_min_select.sv
// Bench for char_min_select: directed plan plus random frames
// checked each cycle against a behavioural frame model.
module tb_char_min_select;

  logic         clk = 1'b0;
  logic         srst, frame_start, frame_end, cmp_valid;
  logic [2:0]   cmp_pos;
  logic [3:0]   cmp_idx;
  logic [15:0]  cmp_diff;
  logic [27:0]  char_index_c;
  logic [111:0] char_diff_c;
  logic         char_valid_c, busy, pos_err;

  int checks = 0;
  int failures = 0;

  char_min_select dut (
    .clk(clk), .srst(srst),
    .frame_start(frame_start), .frame_end(frame_end),
    .cmp_valid(cmp_valid), .cmp_pos(cmp_pos),
    .cmp_idx(cmp_idx), .cmp_diff(cmp_diff),
    .char_index_c(char_index_c), .char_diff_c(char_diff_c),
    .char_valid_c(char_valid_c), .busy(busy), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: frame in progress, best per position, published result.
  bit          m_in_frame, m_pulse, m_perr;
  logic [3:0]  m_best_i [7];
  logic [15:0] m_best_d [7];
  logic [3:0]  m_out_i  [7];
  logic [15:0] m_out_d  [7];

  function automatic void m_clear_best();
    for (int k = 0; k < 7; k++) begin
      m_best_i[k] = 4'hA;
      m_best_d[k] = 16'hFFFF;
    end
  endfunction

  function automatic void m_edge();
    if (srst) begin
      m_in_frame = 0; m_pulse = 0; m_perr = 0;
      m_clear_best();
      m_out_i = m_best_i;
      m_out_d = m_best_d;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (!m_in_frame) begin
      if (frame_start) begin
        m_in_frame = 1; m_perr = 0;
        m_clear_best();
      end
    end else if (frame_start) begin
      m_perr = 0;
      m_clear_best();
    end else begin
      if (cmp_valid) begin
        if (int'(cmp_pos) < 7) begin
          if (cmp_diff < m_best_d[cmp_pos]) begin
            m_best_i[cmp_pos] = cmp_idx;
            m_best_d[cmp_pos] = cmp_diff;
          end
        end else m_perr = 1;
      end
      if (frame_end) begin
        m_out_i = m_best_i;
        m_out_d = m_best_d;
        m_pulse = 1;
        m_in_frame = 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic compare();
    logic [27:0]  ei;
    logic [111:0] ed;
    for (int k = 0; k < 7; k++) begin
      ei[k*4 +: 4]   = m_out_i[k];
      ed[k*16 +: 16] = m_out_d[k];
    end
    chk("valid", {127'd0, char_valid_c}, {127'd0, m_pulse});
    chk("busy", {127'd0, busy}, {127'd0, m_in_frame});
    chk("pos_err", {127'd0, pos_err}, {127'd0, m_perr});
    chk("index", {100'd0, char_index_c}, {100'd0, ei});
    chk("diff", {16'd0, char_diff_c}, {16'd0, ed});
  endtask

  task automatic step(input logic r, input logic fs, input logic fe,
                      input logic cv, input logic [2:0] p,
                      input logic [3:0] ix, input logic [15:0] df);
    srst = r; frame_start = fs; frame_end = fe;
    cmp_valid = cv; cmp_pos = p; cmp_idx = ix; cmp_diff = df;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'd0, 4'd0, 16'd0);
  endtask
  task automatic fstart();
    step(0, 1, 0, 0, 3'd0, 4'd0, 16'd0);
  endtask
  task automatic fend();
    step(0, 0, 1, 0, 3'd0, 4'd0, 16'd0);
  endtask
  task automatic smp(input logic [2:0] p, input logic [3:0] ix,
                     input logic [15:0] df);
    step(0, 0, 0, 1, p, ix, df);
  endtask

  localparam logic [111:0] ALL_FF = {7{16'hFFFF}};

  initial begin
    // 1: reset and idle
    step(1, 0, 0, 0, 3'd0, 4'd0, 16'd0);
    idle(); idle(); idle();
    chk("t1_index", {100'd0, char_index_c}, {100'd0, 28'hAAAAAAA});
    chk("t1_diff", {16'd0, char_diff_c}, {16'd0, ALL_FF});
    chk("t1_valid", {127'd0, char_valid_c}, 128'd0);

    // 2: basic minimum selection
    fstart();
    chk("t2_busy", {127'd0, busy}, 128'd1);
    smp(3'd0, 4'd3, 16'h40);
    smp(3'd0, 4'd1, 16'h10);
    smp(3'd0, 4'd5, 16'h20);
    smp(3'd1, 4'd2, 16'h10);
    fend();
    chk("t2_valid", {127'd0, char_valid_c}, 128'd1);
    chk("t2_index", {100'd0, char_index_c}, {100'd0, 28'hAAAAA21});
    chk("t2_diff", {16'd0, char_diff_c},
        {16'd0, {5{16'hFFFF}}, 16'h0010, 16'h0010});
    idle();
    chk("t2_pulse1", {127'd0, char_valid_c}, 128'd0);
    chk("t2_hold", {100'd0, char_index_c}, {100'd0, 28'hAAAAA21});

    // 3: tie keeps earlier; sample with frame_end is included
    fstart();
    smp(3'd4, 4'd7, 16'h30);
    smp(3'd4, 4'd9, 16'h30);
    step(0, 0, 1, 1, 3'd4, 4'd6, 16'h05);
    chk("t3a_index", {100'd0, char_index_c}, {100'd0, 28'hAA6AAAA});
    chk("t3a_diff", {16'd0, char_diff_c},
        {16'd0, 16'hFFFF, 16'hFFFF, 16'h0005, {4{16'hFFFF}}});
    idle();
    fstart();
    smp(3'd4, 4'd7, 16'h30);
    smp(3'd4, 4'd9, 16'h30);
    smp(3'd3, 4'd2, 16'hFFFF);
    fend();
    chk("t3b_index", {100'd0, char_index_c}, {100'd0, 28'hAA7AAAA});
    chk("t3b_diff", {16'd0, char_diff_c},
        {16'd0, 16'hFFFF, 16'hFFFF, 16'h0030, {4{16'hFFFF}}});
    idle();

    // 4: out-of-range position
    fstart();
    smp(3'd7, 4'd1, 16'h01);
    fend();
    chk("t4_perr", {127'd0, pos_err}, 128'd1);
    chk("t4_index", {100'd0, char_index_c}, {100'd0, 28'hAAAAAAA});
    idle(); idle();
    chk("t4_perr_hold", {127'd0, pos_err}, 128'd1);
    fstart();
    chk("t4_perr_clr", {127'd0, pos_err}, 128'd0);

    // 5: restart mid-frame
    smp(3'd0, 4'd2, 16'h08);
    fstart();
    smp(3'd0, 4'd4, 16'h50);
    fend();
    chk("t5_index", {100'd0, char_index_c}, {100'd0, 28'hAAAAAA4});
    chk("t5_diff", {16'd0, char_diff_c},
        {16'd0, {6{16'hFFFF}}, 16'h0050});
    idle();

    // 6: reset mid-frame
    fstart();
    smp(3'd2, 4'd1, 16'h01);
    step(1, 0, 0, 0, 3'd0, 4'd0, 16'd0);
    chk("t6_busy", {127'd0, busy}, 128'd0);
    fend();
    chk("t6_valid", {127'd0, char_valid_c}, 128'd0);
    chk("t6_index", {100'd0, char_index_c}, {100'd0, 28'hAAAAAAA});
    chk("t6_diff", {16'd0, char_diff_c}, {16'd0, ALL_FF});

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic r, fs, fe, cv;
      logic [15:0] df;
      r  = ($urandom_range(0, 299) == 0);
      fs = ($urandom_range(0, 15) == 0);
      fe = ($urandom_range(0, 9) == 0);
      cv = ($urandom_range(0, 1) == 1);
      df = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                       : 16'($urandom_range(0, 63));
      step(r, fs, fe, cv, 3'($urandom_range(0, 7)),
           4'($urandom), df);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
